// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: request/ready memory-bus controller between the core memory port and a
// synchronous RAM. It adds configurable read wait states, trapping of out-of-range or
// conflicting requests, an acceptance hold, and saturating good-read/good-write counters.
module mem_bus_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] req_rdata,
  output logic              req_ready,
  output logic              busy,
  output logic              addr_err,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned WCNT_W     = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              lat_read;
  logic              lat_bad;
  logic              req_bad_c;

  // A request is bad if it addresses beyond the RAM or asks for read and write at once
  assign req_bad_c = (req_addr[REQ_ADDR_W-1:ADDR_W] != '0) || (req_read && req_write);

  // Busy is decoded directly from the state register
  assign busy = (state != S_IDLE);

  // Access sequencer: accept, strobe RAM for one cycle, wait out latency, complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      lat_read  <= 1'b0;
      lat_bad   <= 1'b0;
      req_rdata <= '0;
      req_ready <= 1'b0;
      addr_err  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      req_ready <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      // A clear in the same cycle as a new error loses: the set below overrides it
      if (err_clr) addr_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!hold && (req_read || req_write)) begin
            mem_addr  <= req_addr[ADDR_W-1:0];
            mem_wdata <= req_wdata;
            lat_read  <= req_read;
            lat_bad   <= req_bad_c;
            mem_re    <= req_read  && !req_bad_c;
            mem_we    <= req_write && !req_bad_c;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          wcnt  <= WCNT_W'(WAIT_STATES);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            state     <= S_DONE;
            req_ready <= 1'b1;
            if (lat_bad) begin
              addr_err  <= 1'b1;
              req_rdata <= '0;
            end else if (lat_read) begin
              req_rdata <= mem_rdata;
              if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            end else begin
              if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
            end
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a zero-wait-state instance with a RAM model and a
// three-wait-state, 2-bit-counter instance with a fixed-content ROM-like RAM model.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=0, CNT_W=16
  logic        hold0, rd0, wr0, errclr0;
  logic [31:0] addr0, wd0, rdata0, mwd0, mrd0;
  logic        ready0, busy0, aerr0, mre0, mwe0;
  logic [8:0]  maddr0;
  logic [15:0] rc0, wc0;

  // Instance 1: WAIT_STATES=3, CNT_W=2
  logic        hold1, rd1, wr1, errclr1;
  logic [31:0] addr1, wd1, rdata1, mwd1, mrd1;
  logic        ready1, busy1, aerr1, mre1, mwe1;
  logic [8:0]  maddr1;
  logic [1:0]  rc1, wc1;

  logic [31:0] ram0 [512];

  int nvec = 0;
  int nerr = 0;

  mem_bus_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .hold(hold0), .req_read(rd0), .req_write(wr0),
    .req_addr(addr0), .req_wdata(wd0), .req_rdata(rdata0), .req_ready(ready0),
    .busy(busy0), .addr_err(aerr0), .err_clr(errclr0), .mem_addr(maddr0),
    .mem_wdata(mwd0), .mem_re(mre0), .mem_we(mwe0), .mem_rdata(mrd0),
    .rd_count(rc0), .wr_count(wc0)
  );

  mem_bus_ctrl #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(3), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .hold(hold1), .req_read(rd1), .req_write(wr1),
    .req_addr(addr1), .req_wdata(wd1), .req_rdata(rdata1), .req_ready(ready1),
    .busy(busy1), .addr_err(aerr1), .err_clr(errclr1), .mem_addr(maddr1),
    .mem_wdata(mwd1), .mem_re(mre1), .mem_we(mwe1), .mem_rdata(mrd1),
    .rd_count(rc1), .wr_count(wc1)
  );

  // Synchronous RAM, one-cycle read latency, read data held between reads
  always @(posedge clk) begin
    if (mwe0) ram0[maddr0] <= mwd0;
    if (mre0) mrd0 <= ram0[maddr0];
  end

  // Preloaded RAM for instance 1: word 0x1FF holds 0x12345678
  always @(posedge clk) begin
    if (mre1) mrd1 <= (maddr1 == 9'h1FF) ? 32'h12345678 : 32'h0000_0000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one access on instance d; returns ready latency in cycles after acceptance,
  // number of sampled mem_re/mem_we cycles, and the read data seen with req_ready
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold_mid,
                        output int lat, output int nre, output int nwe,
                        output logic [31:0] rd);
    lat = -1; nre = 0; nwe = 0; rd = '0;
    @(negedge clk);
    if (d == 0) begin rd0 = r; wr0 = w; addr0 = a; wd0 = wd; end
    else        begin rd1 = r; wr1 = w; addr1 = a; wd1 = wd; end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 0 && hold_mid) begin
        if (d == 0) hold0 = 1'b1; else hold1 = 1'b1;
      end
      nre += (d == 0) ? int'(mre0) : int'(mre1);
      nwe += (d == 0) ? int'(mwe0) : int'(mwe1);
      if (((d == 0) ? ready0 : ready1) === 1'b1) begin
        lat = k;
        rd  = (d == 0) ? rdata0 : rdata1;
        break;
      end
    end
    if (d == 0) begin rd0 = 1'b0; wr0 = 1'b0; hold0 = 1'b0; end
    else        begin rd1 = 1'b0; wr1 = 1'b0; hold1 = 1'b0; end
    @(posedge clk); #1;
  endtask

  int          lat, nre, nwe, nbusy;
  logic [31:0] rdv;

  initial begin
    reset = 1'b1;
    hold0 = 0; rd0 = 0; wr0 = 0; errclr0 = 0; addr0 = 0; wd0 = 0;
    hold1 = 0; rd1 = 0; wr1 = 0; errclr1 = 0; addr1 = 0; wd1 = 0;
    #12;
    chk("reset_busy", 32'(busy0), 32'h0);
    chk("reset_ready", 32'(ready0), 32'h0);
    chk("reset_rdcnt", 32'(rc0), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Write then read back with no wait states
    access(0, 1'b0, 1'b1, 32'h005, 32'hDEADBEEF, 1'b0, lat, nre, nwe, rdv);
    chk("w0_wr_lat", 32'(lat), 32'd2);
    chk("w0_wr_we_cycles", 32'(nwe), 32'd1);
    chk("w0_wr_re_cycles", 32'(nre), 32'd0);
    chk("w0_busy_after", 32'(busy0), 32'h0);
    access(0, 1'b1, 1'b0, 32'h005, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("w0_rd_lat", 32'(lat), 32'd2);
    chk("w0_rd_re_cycles", 32'(nre), 32'd1);
    chk("w0_rd_data", rdv, 32'hDEADBEEF);
    chk("w0_rd_count", 32'(rc0), 32'd1);
    chk("w0_wr_count", 32'(wc0), 32'd1);
    chk("w0_no_err", 32'(aerr0), 32'h0);

    // Out-of-range read
    access(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("err_oor_lat", 32'(lat), 32'd2);
    chk("err_oor_strobes", 32'(nre + nwe), 32'd0);
    chk("err_oor_rdata", rdv, 32'h0);
    chk("err_oor_flag", 32'(aerr0), 32'h1);
    chk("err_oor_rdcnt", 32'(rc0), 32'd1);

    // Clear, then read+write together
    @(negedge clk); errclr0 = 1'b1;
    @(posedge clk); #1; errclr0 = 1'b0;
    chk("err_clr1", 32'(aerr0), 32'h0);
    access(0, 1'b1, 1'b1, 32'h001, 32'hAAAA5555, 1'b0, lat, nre, nwe, rdv);
    chk("err_rw_strobes", 32'(nre + nwe), 32'd0);
    chk("err_rw_rdata", rdv, 32'h0);
    chk("err_rw_flag", 32'(aerr0), 32'h1);
    chk("err_rw_rdcnt", 32'(rc0), 32'd1);
    chk("err_rw_wrcnt", 32'(wc0), 32'd1);
    @(negedge clk); errclr0 = 1'b1;
    @(posedge clk); #1; errclr0 = 1'b0;
    chk("err_clr2", 32'(aerr0), 32'h0);

    // Hold blocks acceptance for 10 cycles
    @(negedge clk); hold0 = 1'b1; rd0 = 1'b1; addr0 = 32'h005;
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      nbusy += int'(busy0);
    end
    chk("hold_busy_cycles", 32'(nbusy), 32'd0);
    @(negedge clk); hold0 = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_busy", 32'(busy0), 32'h1);
    lat = -1;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
      if (ready0 === 1'b1) begin lat = k; rdv = rdata0; break; end
    end
    rd0 = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_lat", 32'(lat), 32'd2);
    chk("hold_release_data", rdv, 32'hDEADBEEF);

    // Hold raised mid-access does not stop it
    access(0, 1'b1, 1'b0, 32'h005, 32'h0, 1'b1, lat, nre, nwe, rdv);
    chk("hold_mid_lat", 32'(lat), 32'd2);
    chk("hold_mid_data", rdv, 32'hDEADBEEF);
    chk("hold_mid_rdcnt", 32'(rc0), 32'd3);

    // Asynchronous reset during a write strobe
    @(negedge clk); wr0 = 1'b1; addr0 = 32'h009; wd0 = 32'h11111111;
    @(posedge clk); #1;
    chk("rst_we_before", 32'(mwe0), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_we_now", 32'(mwe0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_maddr", 32'(maddr0), 32'h0);
    chk("rst_mwdata", mwd0, 32'h0);
    chk("rst_rdcnt", 32'(rc0), 32'h0);
    chk("rst_wrcnt", 32'(wc0), 32'h0);
    wr0 = 1'b0;
    @(negedge clk); reset = 1'b0;
    access(0, 1'b0, 1'b1, 32'h007, 32'hCAFEF00D, 1'b0, lat, nre, nwe, rdv);
    chk("post_rst_wr_lat", 32'(lat), 32'd2);
    access(0, 1'b1, 1'b0, 32'h007, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("post_rst_rd_data", rdv, 32'hCAFEF00D);
    chk("post_rst_counts", {16'(rc0), 16'(wc0)}, {16'd1, 16'd1});

    // Three wait states, top address
    access(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("w3_lat", 32'(lat), 32'd5);
    chk("w3_re_cycles", 32'(nre), 32'd1);
    chk("w3_data", rdv, 32'h12345678);
    chk("w3_rdcnt1", 32'(rc1), 32'd1);

    // Saturation of a 2-bit counter
    access(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("sat_rdcnt2", 32'(rc1), 32'd2);
    access(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("sat_rdcnt3", 32'(rc1), 32'd3);
    access(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("sat_rdcnt4", 32'(rc1), 32'd3);
    access(1, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b0, lat, nre, nwe, rdv);
    chk("sat_rdcnt5", 32'(rc1), 32'd3);
    chk("sat_wrcnt", 32'(wc1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
